// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller handshake bundle.
// Groups the per-stage hazard inputs coming from the core datapath/decode
// and the enable/flush/forward outputs going back to the pipeline registers.
//   master : core side (drives register/hazard info, receives controls)
//   slave  : pipeline_hazard_ctrl (receives hazard info, drives controls)
// Parameter RA_W: register-address width.
interface pipeline_hazard_ctrl_if #(
    parameter int RA_W = 5
);
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [RA_W-1:0] ex_rd;
    logic            ex_rb_wr;
    logic            ex_is_load;
    logic            ex_redirect;
    logic [RA_W-1:0] mem_rd;
    logic [RA_W-1:0] wb_rd;
    logic            mem_rb_wr;
    logic            wb_rb_wr;
    logic            mem_dm_req;
    logic            dm_ack;

    logic            pc_en;
    logic            if_id_en;
    logic            id_ex_en;
    logic            ex_mem_en;
    logic            mem_wb_en;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            mem_wait;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_rb_wr, ex_is_load, ex_redirect,
        output mem_rd, wb_rd, mem_rb_wr, wb_rb_wr,
        output mem_dm_req, dm_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, fwd_a, fwd_b, mem_wait
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_rb_wr, ex_is_load, ex_redirect,
        input  mem_rd, wb_rd, mem_rb_wr, wb_rb_wr,
        input  mem_dm_req, dm_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, fwd_a, fwd_b, mem_wait
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage RV32I pipeline.
// Drives PC / pipeline-register enables and flushes, detects load-use and
// EX redirects, freezes the pipe across multi-cycle data-memory accesses and
// selects EX operand forwarding.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-high reset
//   hz   - pipeline_hazard_ctrl_if.slave (hazard inputs, control outputs)
//   stall_cycles, mem_wait_cycles, flush_count - 32-bit event counters,
//          present only when HAZARD_PERF_CNT_EN is defined
//
// state    | meaning
// RUN      | normal flow; a pending data access without ack freezes the pipe
// MEM_WAIT | data access outstanding; pipe frozen until dm_ack
module pipeline_hazard_ctrl #(
    parameter int RA_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           mem_wait_cycles,
    output logic [31:0]           flush_count
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            freeze;
    logic            load_use;
    logic            stall_evt;
    logic            redir_evt;
    logic [RA_W-1:0] ex_rs1;
    logic [RA_W-1:0] ex_rs2;
    logic            ex_use1;
    logic            ex_use2;

    logic            pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic            if_id_flush_c, id_ex_flush_c;
    logic [1:0]      fwd_a_c, fwd_b_c;

    assign load_use = hz.ex_is_load && hz.ex_rb_wr && (hz.ex_rd != '0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // MEM beats WB because MEM holds the younger result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] rs,
        input logic            use_rs,
        input logic [RA_W-1:0] m_rd,
        input logic            m_wr,
        input logic [RA_W-1:0] w_rd,
        input logic            w_wr
    );
        if (use_rs && m_wr && (m_rd != '0) && (m_rd == rs))
            return 2'b01;
        else if (use_rs && w_wr && (w_rd != '0) && (w_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        freeze        = 1'b0;
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        id_ex_en_c    = 1'b1;
        ex_mem_en_c   = 1'b1;
        mem_wb_en_c   = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        stall_evt     = 1'b0;
        redir_evt     = 1'b0;

        case (state)
            RUN: begin
                if (hz.mem_dm_req && !hz.dm_ack) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.dm_ack)
                    state_nxt = RUN;
                else
                    freeze = 1'b1;
            end
            default: state_nxt = RUN;
        endcase

        if (rst) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_en_c    = 1'b0;
            ex_mem_en_c   = 1'b0;
            mem_wb_en_c   = 1'b0;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            freeze        = 1'b0;
        end else if (freeze) begin
            // EX is held, so a pending redirect/load-use re-presents after release.
            pc_en_c     = 1'b0;
            if_id_en_c  = 1'b0;
            id_ex_en_c  = 1'b0;
            ex_mem_en_c = 1'b0;
            mem_wb_en_c = 1'b0;
        end else if (hz.ex_redirect) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            redir_evt     = 1'b1;
        end else if (load_use) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
            stall_evt     = 1'b1;
        end

        if (rst) begin
            fwd_a_c = 2'b00;
            fwd_b_c = 2'b00;
        end else begin
            fwd_a_c = fwd_sel(ex_rs1, ex_use1, hz.mem_rd, hz.mem_rb_wr, hz.wb_rd, hz.wb_rb_wr);
            fwd_b_c = fwd_sel(ex_rs2, ex_use2, hz.mem_rd, hz.mem_rb_wr, hz.wb_rd, hz.wb_rb_wr);
        end
    end

    // Source copies travel with the ID/EX register; a bubble carries no sources.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_use1 <= 1'b0;
            ex_use2 <= 1'b0;
        end else if (id_ex_en_c) begin
            if (id_ex_flush_c) begin
                ex_rs1  <= '0;
                ex_rs2  <= '0;
                ex_use1 <= 1'b0;
                ex_use2 <= 1'b0;
            end else begin
                ex_rs1  <= hz.id_rs1;
                ex_rs2  <= hz.id_rs2;
                ex_use1 <= hz.id_use_rs1;
                ex_use2 <= hz.id_use_rs2;
            end
        end
    end

    assign hz.pc_en       = pc_en_c;
    assign hz.if_id_en    = if_id_en_c;
    assign hz.id_ex_en    = id_ex_en_c;
    assign hz.ex_mem_en   = ex_mem_en_c;
    assign hz.mem_wb_en   = mem_wb_en_c;
    assign hz.if_id_flush = if_id_flush_c;
    assign hz.id_ex_flush = id_ex_flush_c;
    assign hz.fwd_a       = fwd_a_c;
    assign hz.fwd_b       = fwd_b_c;
    assign hz.mem_wait    = (state == MEM_WAIT) && !rst;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles    <= '0;
            mem_wait_cycles <= '0;
            flush_count     <= '0;
        end else begin
            if (stall_evt) stall_cycles    <= stall_cycles + 32'd1;
            if (freeze)    mem_wait_cycles <= mem_wait_cycles + 32'd1;
            if (redir_evt) flush_count     <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if #(.RA_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, mem_wait_cycles, flush_count;
`endif

    pipeline_hazard_ctrl #(.RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .mem_wait_cycles (mem_wait_cycles),
        .flush_count     (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       use1, use2;
        logic [4:0] ex_rd;
        logic       ex_wr, ex_ld, redir;
        logic [4:0] mem_rd, wb_rd;
        logic       mem_wr, wb_wr, req, ack, rst;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [11:0] e;
    } vec_t;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, fwd_a, fwd_b, mem_wait}
    localparam logic [11:0] E_RUN   = {5'b11111, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_STALL = {5'b00111, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_REDIR = {5'b11111, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_FRZ   = {5'b00000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_FRZW  = {5'b00000, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [11:0] E_ACKW  = {5'b11111, 2'b00, 2'b00, 2'b00, 1'b1};
    localparam logic [11:0] E_RST   = {5'b00000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_FA01  = {5'b11111, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [11:0] E_FA10  = {5'b11111, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [11:0] E_FA10B01 = {5'b11111, 2'b00, 2'b10, 2'b01, 1'b0};

    logic [11:0] obs;
    assign obs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                  bus.if_id_flush, bus.id_ex_flush, bus.fwd_a, bus.fwd_b, bus.mem_wait};

    logic [11:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{id_rs1: 5'd0, id_rs2: 5'd0, use1: 1'b0, use2: 1'b0, ex_rd: 5'd0,
              ex_wr: 1'b0, ex_ld: 1'b0, redir: 1'b0, mem_rd: 5'd0, wb_rd: 5'd0,
              mem_wr: 1'b0, wb_wr: 1'b0, req: 1'b0, ack: 1'b0, rst: 1'b0};
        return s;
    endfunction

    // Drives one cycle of inputs, queues its expectation, waits for the sample point.
    task automatic drive_cycle(input vec_t v);
        rst            = v.s.rst;
        bus.id_rs1     = v.s.id_rs1;
        bus.id_rs2     = v.s.id_rs2;
        bus.id_use_rs1 = v.s.use1;
        bus.id_use_rs2 = v.s.use2;
        bus.ex_rd      = v.s.ex_rd;
        bus.ex_rb_wr   = v.s.ex_wr;
        bus.ex_is_load = v.s.ex_ld;
        bus.ex_redirect = v.s.redir;
        bus.mem_rd     = v.s.mem_rd;
        bus.wb_rd      = v.s.wb_rd;
        bus.mem_rb_wr  = v.s.mem_wr;
        bus.wb_rb_wr   = v.s.wb_wr;
        bus.mem_dm_req = v.s.req;
        bus.dm_ack     = v.s.ack;
        exp_q.push_back(v.e);
        @(negedge clk);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t  v[$];
        stim_t s;
        logic [11:0] e;
        s = idle(); s.rst = 1'b1; s.redir = 1'b1; s.req = 1'b1;
        v.push_back('{s, E_RST});
        v.push_back('{s, E_RST});
        s = idle();
        v.push_back('{s, E_RUN});
        foreach (v[i]) begin
            drive_cycle(v[i]);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got %b want %b", i, obs, e);
            end
            next_edge();
        end
    endtask

    task automatic test_load_use();
        vec_t  v[$];
        stim_t s;
        logic [11:0] e;
        s = idle(); s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1;
        v.push_back('{s, E_STALL});
        s = idle(); s.id_rs1 = 5; s.use1 = 1;
        v.push_back('{s, E_RUN});
        s = idle(); s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 12; s.id_rs2 = 12; s.use2 = 1;
        v.push_back('{s, E_STALL});
        s = idle(); s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 0;
        v.push_back('{s, E_RUN});
        s = idle(); s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 0; s.id_rs1 = 0; s.use1 = 1;
        v.push_back('{s, E_RUN});
        s = idle(); s.ex_ld = 1; s.ex_wr = 0; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1;
        v.push_back('{s, E_RUN});
        s = idle(); s.ex_ld = 0; s.ex_wr = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1;
        v.push_back('{s, E_RUN});
        foreach (v[i]) begin
            drive_cycle(v[i]);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_use[%0d] got %b want %b", i, obs, e);
            end
            next_edge();
        end
    endtask

    task automatic test_redirect();
        vec_t  v[$];
        stim_t s;
        logic [11:0] e;
        s = idle(); s.redir = 1; s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1;
        v.push_back('{s, E_REDIR});
        s = idle(); s.redir = 1;
        v.push_back('{s, E_REDIR});
        s = idle();
        v.push_back('{s, E_RUN});
        foreach (v[i]) begin
            drive_cycle(v[i]);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL redirect[%0d] got %b want %b", i, obs, e);
            end
            next_edge();
        end
    endtask

    task automatic test_forward();
        vec_t  v[$];
        stim_t s;
        logic [11:0] e;
        s = idle(); s.id_rs1 = 7; s.use1 = 1; s.id_rs2 = 9; s.use2 = 1;
        v.push_back('{s, E_RUN});
        s.mem_rd = 7; s.mem_wr = 1; s.wb_rd = 7; s.wb_wr = 1;
        v.push_back('{s, E_FA01});
        s.mem_wr = 0;
        v.push_back('{s, E_FA10});
        s.mem_rd = 9; s.mem_wr = 1;
        v.push_back('{s, E_FA10B01});
        s = idle(); s.id_rs1 = 0; s.use1 = 1; s.id_rs2 = 0; s.use2 = 1;
        v.push_back('{s, E_RUN});
        s.mem_rd = 0; s.mem_wr = 1; s.wb_rd = 0; s.wb_wr = 1;
        v.push_back('{s, E_RUN});
        // a load-use bubble must leave EX with no sources to forward
        s = idle(); s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 7; s.id_rs1 = 7; s.use1 = 1;
        v.push_back('{s, E_STALL});
        s = idle(); s.id_rs1 = 7; s.use1 = 1; s.mem_rd = 7; s.mem_wr = 1;
        v.push_back('{s, E_RUN});
        s = idle(); s.id_rs1 = 7; s.use1 = 1; s.mem_rd = 7; s.mem_wr = 1;
        v.push_back('{s, E_FA01});
        foreach (v[i]) begin
            drive_cycle(v[i]);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL forward[%0d] got %b want %b", i, obs, e);
            end
            next_edge();
        end
    endtask

    task automatic test_mem_wait();
        vec_t  v[$];
        stim_t s;
        logic [11:0] e;
        s = idle(); s.req = 1; s.redir = 1;
        v.push_back('{s, E_FRZ});
        s = idle(); s.req = 1; s.ex_ld = 1; s.ex_wr = 1; s.ex_rd = 3; s.id_rs1 = 3; s.use1 = 1;
        v.push_back('{s, E_FRZW});
        s = idle(); s.req = 1;
        v.push_back('{s, E_FRZW});
        s.ack = 1;
        v.push_back('{s, E_ACKW});
        s = idle();
        v.push_back('{s, E_RUN});
        s.req = 1; s.ack = 1;
        v.push_back('{s, E_RUN});
        s = idle();
        v.push_back('{s, E_RUN});
        foreach (v[i]) begin
            drive_cycle(v[i]);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mem_wait[%0d] got %b want %b", i, obs, e);
            end
            next_edge();
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t  v[$];
        stim_t s;
        logic [11:0] e;
        s = idle(); s.req = 1;
        v.push_back('{s, E_FRZ});
        v.push_back('{s, E_FRZW});
        s.rst = 1;
        v.push_back('{s, E_RST});
        s = idle();
        v.push_back('{s, E_RUN});
        s.req = 1; s.ack = 1;
        v.push_back('{s, E_RUN});
        foreach (v[i]) begin
            drive_cycle(v[i]);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_wait[%0d] got %b want %b", i, obs, e);
            end
            next_edge();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        vec_t  v[$];
        stim_t s;
        stim_t lu;
        logic [11:0] e;
        lu = idle(); lu.ex_ld = 1; lu.ex_wr = 1; lu.ex_rd = 4; lu.id_rs2 = 4; lu.use2 = 1;
        s = lu; s.rst = 1; s.redir = 1;
        v.push_back('{s, E_RST});
        v.push_back('{s, E_RST});
        v.push_back('{lu, E_STALL});
        s = idle();
        v.push_back('{s, E_RUN});
        v.push_back('{lu, E_STALL});
        s = idle(); s.req = 1; s.redir = 1;
        v.push_back('{s, E_FRZ});
        s = idle(); s.req = 1;
        v.push_back('{s, E_FRZW});
        v.push_back('{s, E_FRZW});
        v.push_back('{s, E_FRZW});
        s.ack = 1;
        v.push_back('{s, E_ACKW});
        s = idle(); s.redir = 1;
        v.push_back('{s, E_REDIR});
        s = idle();
        v.push_back('{s, E_RUN});
        foreach (v[i]) begin
            drive_cycle(v[i]);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL perf_seq[%0d] got %b want %b", i, obs, e);
            end
            next_edge();
        end
        @(negedge clk);
        n_assert++;
        if (stall_cycles !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_cycles got %0d want 2", stall_cycles);
        end
        n_assert++;
        if (mem_wait_cycles !== 32'd4) begin
            n_fail++;
            $display("FAIL mem_wait_cycles got %0d want 4", mem_wait_cycles);
        end
        n_assert++;
        if (flush_count !== 32'd1) begin
            n_fail++;
            $display("FAIL flush_count got %0d want 1", flush_count);
        end
        next_edge();
    endtask
`endif

    initial begin
        vec_t v0;
        v0.s = idle();
        v0.s.rst = 1'b1;
        v0.e = E_RST;
        rst = 1'b1;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.ex_rd = '0; bus.ex_rb_wr = 0; bus.ex_is_load = 0; bus.ex_redirect = 0;
        bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_rb_wr = 0; bus.wb_rb_wr = 0;
        bus.mem_dm_req = 0; bus.dm_ack = 0;
        drive_cycle(v0);
        void'(exp_q.pop_front());
        next_edge();

        test_reset();
        test_load_use();
        test_redirect();
        test_forward();
        test_mem_wait();
        test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage pipelined RV32I core: sequences the IF/ID/EX/MEM/WB pipeline registers. Detects load-use hazards and taken-branch/jump redirects. Holds the pipeline across multi-cycle data-memory accesses and generates EX-stage operand forwarding selects. Sits beside the per-stage decode/control logic and drives the enables and flushes of every pipeline register plus the PC.

## Interface
Parameters:
- RA_W, 5, register-address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  RA_W  source registers of instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rd  in  RA_W  destination register of EX instruction.
- ex_rb_wr  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR (PC loads target).
- mem_rd, wb_rd  in  RA_W  destination registers in MEM and WB.
- mem_rb_wr, wb_rb_wr  in  1  MEM/WB instruction writes the register file.
- mem_dm_req  in  1  MEM instruction is a load/store, access in progress.
- dm_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline register enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (NOP, all write-enables 0) into the register.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB result.
- mem_wait  out  1  FSM is in MEM_WAIT.

## Operation
- FSM states: RUN, MEM_WAIT. Reset state RUN.
- RUN -> MEM_WAIT when mem_dm_req=1 and dm_ack=0. MEM_WAIT -> RUN in the cycle dm_ack=1. In RUN, mem_dm_req with dm_ack=1 causes no stall.
- Freeze (state RUN with mem_dm_req=1 and dm_ack=0, or state MEM_WAIT with dm_ack=0): all enables 0, flushes 0. Redirect and load-use are ignored; because EX is frozen, they reappear after the release.
- Load-use: ex_is_load=1, ex_rb_wr=1, ex_rd!=0, and ex_rd matches an ID source that is used. Response: pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1. Exactly one bubble is inserted.
- Redirect: ex_redirect=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1. Redirect overrides load-use in the same cycle.
- Otherwise all enables 1, flushes 0.
- Internal ex_rs1/ex_rs2/ex_use copies are captured from the ID inputs whenever id_ex_en=1. They are cleared to 0 when id_ex_flush=1.
- Forwarding, per operand, uses the captured copy and is combinational:
  - 01 if mem_rb_wr, mem_rd!=0 and mem_rd==ex_rs.
  - Else 10 if wb_rb_wr, wb_rd!=0 and wb_rd==ex_rs.
  - Else 00.
  - MEM has priority over WB. x0 is never forwarded.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the registered state, valid in the same cycle.
- Freeze releases combinationally in the dm_ack cycle: all enables are 1 in that cycle.
- While rst=1: pc_en=0, all stage enables 0, if_id_flush=1, id_ex_flush=1, fwd_a=fwd_b=00, mem_wait=0.
- On the first cycle after rst deasserts, the state is RUN, captured sources are 0, and outputs follow the rules above.
- rst during MEM_WAIT aborts the wait: the next cycle is RUN with no pending stall.

## Configuration
- HAZARD_PERF_CNT_EN: when defined, adds three 32-bit outputs, each incrementing once per cycle of its event:
  - stall_cycles: load-use cycles.
  - mem_wait_cycles: freeze cycles.
  - flush_count: redirect cycles.
- The counters wrap at 2^32, reset to 0 on rst, and do not count during rst.
- When the macro is not defined, these ports and registers do not exist and behaviour is otherwise identical.

## Test plan
- Load-use: ex_is_load=1, ex_rb_wr=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. The next cycle (bubble in EX) is all enables 1.
- Redirect plus load-use in the same cycle: ex_redirect=1 with the load-use condition -> pc_en=1, if_id_flush=1, id_ex_flush=1.
- Memory wait: mem_dm_req=1, dm_ack low for 3 cycles then high:
  - mem_wait=1 for cycles 2-3.
  - All enables 0 for cycles 1-3.
  - All enables 1 in the ack cycle.
  - mem_wait=0 in the following cycle.
- Forward priority: captured ex_rs1=7, mem_rd=7/mem_rb_wr=1, wb_rd=7/wb_rb_wr=1 -> fwd_a=01. Clearing mem_rb_wr -> fwd_a=10. With ex_rs1=0 and both writers targeting x0 -> fwd_a=00.
- Reset mid-wait: assert rst while in MEM_WAIT -> outputs take reset values that cycle. After release: mem_wait=0 and all enables 1 with mem_dm_req=0.
- With HAZARD_PERF_CNT_EN: 2 load-use events, 4 freeze cycles and 1 redirect -> stall_cycles=2, mem_wait_cycles=4, flush_count=1.
